// File: rtl/rv32i_mini_soc.sv
// rv32i_mini_soc: single-cycle RV32I core with Harvard instruction/data memories,
// one memory-mapped 32-bit GPIO port and per-instruction RVFI-style trace outputs.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   o_flash_*, i_flash_miso flash SPI pins, held idle / ignored
//   o_uart_tx, i_uart_rx    UART pins, held idle / ignored
//   io_data                 GPIO pins, bit i driven by gpio_out[i] when gpio_dir[i]=1
//   rvfi_*                  retirement trace of the instruction committing this cycle
module rv32i_mini_soc #(
   parameter int unsigned IMEM_DEPTH = 100000,
   parameter int unsigned DMEM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        o_flash_sclk,
   output logic        o_flash_cs_n,
   output logic        o_flash_mosi,
   input  logic        i_flash_miso,
   output logic        o_uart_tx,
   input  logic        i_uart_rx,
   inout  wire  [31:0] io_data,
   output logic        rvfi_valid,
   output logic [31:0] rvfi_insn,
   output logic [31:0] rvfi_pc_rdata,
   output logic [31:0] rvfi_pc_wdata,
   output logic [4:0]  rvfi_rs1_addr,
   output logic [4:0]  rvfi_rs2_addr,
   output logic [31:0] rvfi_rs1_rdata,
   output logic [31:0] rvfi_rs2_rdata,
   output logic [4:0]  rvfi_rd_addr,
   output logic [31:0] rvfi_rd_wdata
);
   localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   // Storage; imem/dmem are preloaded hierarchically and never reset
   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] dmem [DMEM_DEPTH];
   logic [31:0] regs [32];
   logic [31:0] pc;
   logic [31:0] gpio_out;
   logic [31:0] gpio_dir;

   logic [31:0] insn;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
   logic [31:0] mem_addr;
   logic        in_dmem;
   logic [DAW-1:0] dmem_idx;
   logic [31:0] rd_word;
   logic [31:0] load_val;
   logic        load_ok;
   logic        br_taken;
   logic [31:0] next_pc;
   logic        rd_we;
   logic [31:0] rd_val;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        gpio_out_we;
   logic        gpio_dir_we;
   logic        unused;

   assign o_flash_sclk = 1'b0;
   assign o_flash_cs_n = 1'b1;
   assign o_flash_mosi = 1'b0;
   assign o_uart_tx    = 1'b1;
   assign unused       = ^{i_flash_miso, i_uart_rx};

   // Per-bit tristate GPIO drivers
   for (genvar g = 0; g < 32; g++) begin : g_gpio
      assign io_data[g] = gpio_dir[g] ? gpio_out[g] : 1'bz;
   end

   // Fetch and decode; beyond the end of imem reads as NOP
   assign insn   = (pc[31:2] < 30'(IMEM_DEPTH)) ? imem[pc[IAW+1:2]] : NOP;
   assign opcode = insn[6:0];
   assign rd     = insn[11:7];
   assign funct3 = insn[14:12];
   assign rs1    = insn[19:15];
   assign rs2    = insn[24:20];
   assign imm_i  = {{20{insn[31]}}, insn[31:20]};
   assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u  = {insn[31:12], 12'h000};
   assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

   // ALU shared by OP and OP-IMM; insn[30] selects SUB/SRA
   always_comb begin
      alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
      alu_res = 32'h0;
      case (funct3)
         3'b000: alu_res = (opcode == OP_REG && insn[30]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001: alu_res = rs1_val << alu_b[4:0];
         3'b010: alu_res = {31'h0, $signed(rs1_val) < $signed(alu_b)};
         3'b011: alu_res = {31'h0, rs1_val < alu_b};
         3'b100: alu_res = rs1_val ^ alu_b;
         3'b101: alu_res = insn[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
         3'b110: alu_res = rs1_val | alu_b;
         default: alu_res = rs1_val & alu_b;
      endcase
   end

   // Data address decode and combinational load path
   assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign in_dmem  = !mem_addr[31] && (mem_addr[30:2] < 29'(DMEM_DEPTH));
   assign dmem_idx = mem_addr[DAW+1:2];

   always_comb begin
      rd_word  = 32'h0;
      load_val = 32'h0;
      load_ok  = 1'b1;
      if (in_dmem) begin
         rd_word = dmem[dmem_idx];
      end else if (mem_addr[31]) begin
         case (mem_addr[30:0])
            31'h0:   rd_word = gpio_out;
            31'h4:   rd_word = gpio_dir;
            31'h8:   rd_word = io_data;
            default: rd_word = 32'h0;
         endcase
      end
      case (funct3)
         3'b000: load_val = 32'($signed(8'(rd_word >> {mem_addr[1:0], 3'b000})));
         3'b001: load_val = 32'($signed(mem_addr[1] ? rd_word[31:16] : rd_word[15:0]));
         3'b010: load_val = rd_word;
         3'b100: load_val = {24'h0, 8'(rd_word >> {mem_addr[1:0], 3'b000})};
         3'b101: load_val = {16'h0, mem_addr[1] ? rd_word[31:16] : rd_word[15:0]};
         default: load_ok = 1'b0;
      endcase
   end

   // Branch condition
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000: br_taken = (rs1_val == rs2_val);
         3'b001: br_taken = (rs1_val != rs2_val);
         3'b100: br_taken = ($signed(rs1_val) < $signed(rs2_val));
         3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110: br_taken = (rs1_val < rs2_val);
         3'b111: br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   // Execute control: next PC, register write-back, store enables
   always_comb begin
      next_pc     = pc + 32'd4;
      rd_we       = 1'b0;
      rd_val      = 32'h0;
      dmem_be     = 4'b0000;
      dmem_wdata  = rs2_val;
      gpio_out_we = 1'b0;
      gpio_dir_we = 1'b0;
      case (opcode)
         OP_LUI: begin
            rd_we  = 1'b1;
            rd_val = imm_u;
         end
         OP_AUIPC: begin
            rd_we  = 1'b1;
            rd_val = pc + imm_u;
         end
         OP_JAL: begin
            rd_we   = 1'b1;
            rd_val  = pc + 32'd4;
            next_pc = pc + imm_j;
         end
         OP_JALR: begin
            rd_we   = 1'b1;
            rd_val  = pc + 32'd4;
            next_pc = (rs1_val + imm_i) & ~32'h1;
         end
         OP_BRANCH: begin
            if (br_taken) next_pc = pc + imm_b;
         end
         OP_LOAD: begin
            rd_we  = load_ok;
            rd_val = load_val;
         end
         OP_STORE: begin
            case (funct3)
               3'b000: begin
                  dmem_be    = 4'b0001 << mem_addr[1:0];
                  dmem_wdata = {4{rs2_val[7:0]}};
               end
               3'b001: begin
                  dmem_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                  dmem_wdata = {2{rs2_val[15:0]}};
               end
               3'b010: begin
                  dmem_be     = 4'b1111;
                  gpio_out_we = (mem_addr == 32'h8000_0000);
                  gpio_dir_we = (mem_addr == 32'h8000_0004);
               end
               default: dmem_be = 4'b0000;
            endcase
            if (!in_dmem) dmem_be = 4'b0000;
         end
         OP_IMM, OP_REG: begin
            rd_we  = 1'b1;
            rd_val = alu_res;
         end
         default: ;
      endcase
   end

   // Architectural state commit
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc       <= 32'h0;
         gpio_out <= 32'h0;
         gpio_dir <= 32'h0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else begin
         pc <= next_pc;
         if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
         if (gpio_out_we) gpio_out <= rs2_val;
         if (gpio_dir_we) gpio_dir <= rs2_val;
      end
   end

   // Data memory byte-enable write port; suppressed while in reset
   always_ff @(posedge clk) begin
      if (reset_n) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem_be[b]) dmem[dmem_idx][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
         end
      end
   end

   // Trace of the instruction committing at the next rising edge
   assign rvfi_valid     = reset_n;
   assign rvfi_insn      = insn;
   assign rvfi_pc_rdata  = pc;
   assign rvfi_pc_wdata  = next_pc;
   assign rvfi_rs1_addr  = rs1;
   assign rvfi_rs2_addr  = rs2;
   assign rvfi_rs1_rdata = rs1_val;
   assign rvfi_rs2_rdata = rs2_val;
   assign rvfi_rd_addr   = (rd_we && rd != 5'd0) ? rd : 5'd0;
   assign rvfi_rd_wdata  = (rd_we && rd != 5'd0) ? rd_val : 32'h0;

endmodule

// File: tb/tb_rv32i_mini_soc.sv
// Self-checking bench for rv32i_mini_soc: table of single-ALU-op programs plus
// directed programs for loads/stores, loops, jumps, GPIO, imem bound and reset.
module tb_rv32i_mini_soc;
   localparam logic [6:0] OPI = 7'h13;
   localparam logic [6:0] OPL = 7'h03;
   localparam logic [31:0] PARK = 32'h0000_006F;   // JAL x0,0

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flash_sclk, flash_cs_n, flash_mosi, uart_tx;
   logic        flash_miso = 1'b1;
   logic        uart_rx = 1'b0;
   wire  [31:0] io_data;
   logic        ext_en = 1'b0;
   logic [31:0] ext_val = 32'h0;
   logic        rvfi_valid;
   logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
   logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;

   int total = 0;
   int bad = 0;
   logic pin_bad = 1'b0;
   logic [31:0] prog [$];

   assign io_data = ext_en ? ext_val : 32'bz;

   rv32i_mini_soc dut (
      .clk(clk), .reset_n(reset_n),
      .o_flash_sclk(flash_sclk), .o_flash_cs_n(flash_cs_n), .o_flash_mosi(flash_mosi),
      .i_flash_miso(flash_miso), .o_uart_tx(uart_tx), .i_uart_rx(uart_rx),
      .io_data(io_data),
      .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
      .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
      .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
      .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
      .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      flash_miso <= ~flash_miso;
      uart_rx    <= ~uart_rx;
      if (flash_sclk !== 1'b0 || flash_cs_n !== 1'b1 || flash_mosi !== 1'b0 || uart_tx !== 1'b1)
         pin_bad <= 1'b1;
   end

   function automatic logic [31:0] enc_r(int f7, int r2, int r1, int f3, int rd);
      return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(int imm, int r1, int f3, int rd, logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'(r1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int r2, int r1, int f3);
      logic [31:0] v;
      v = imm;
      return {v[11:5], 5'(r2), 5'(r1), 3'(f3), v[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int r2, int r1, int f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'(r2), 5'(r1), 3'(f3), v[4:1], v[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
      logic [31:0] v;
      v = imm20;
      return {v[19:0], 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction

   task automatic li(input int rd, input logic [31:0] a);
      logic [31:0] h;
      h = a + 32'h800;
      prog.push_back({h[31:12], 5'(rd), 7'h37});
      prog.push_back({a[11:0], 5'(rd), 3'b000, 5'(rd), OPI});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold reset, clear memories, load prog, release; returns with insn 0 in flight
   task automatic load_and_reset();
      @(negedge clk);
      reset_n = 1'b0;
      for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
      for (int i = 0; i < 128; i++) dut.dmem[i] = 32'h0;
      foreach (prog[i]) dut.imem[i] = prog[i];
      @(posedge clk);
      @(negedge clk);
      check("reset.valid", 32'(rvfi_valid), 32'h0);
      check("reset.pc", dut.pc, 32'h0);
      reset_n = 1'b1;
   endtask

   typedef struct {
      string       name;
      logic [31:0] insn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];

   initial begin
      logic [31:0] acc;
      int n;
      bit done;

      vecs[0]  = '{"add",   enc_r(0, 2, 1, 0, 3),  32'd5,        32'd7,        32'd12};
      vecs[1]  = '{"sub",   enc_r(32, 2, 1, 0, 3), 32'd5,        32'd7,        32'hFFFF_FFFE};
      vecs[2]  = '{"sll",   enc_r(0, 2, 1, 1, 3),  32'd1,        32'd33,       32'd2};
      vecs[3]  = '{"slt",   enc_r(0, 2, 1, 2, 3),  32'hFFFF_FFFF, 32'd1,       32'd1};
      vecs[4]  = '{"sltu",  enc_r(0, 2, 1, 3, 3),  32'hFFFF_FFFF, 32'd1,       32'd0};
      vecs[5]  = '{"xor",   enc_r(0, 2, 1, 4, 3),  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[6]  = '{"or",    enc_r(0, 2, 1, 6, 3),  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
      vecs[7]  = '{"and",   enc_r(0, 2, 1, 7, 3),  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[8]  = '{"srl",   enc_r(0, 2, 1, 5, 3),  32'h8000_0000, 32'd4,       32'h0800_0000};
      vecs[9]  = '{"sra",   enc_r(32, 2, 1, 5, 3), 32'h8000_0000, 32'd4,       32'hF800_0000};
      vecs[10] = '{"addwrap", enc_r(0, 2, 1, 0, 3), 32'h7FFF_FFFF, 32'd1,      32'h8000_0000};
      vecs[11] = '{"addi",  enc_i(-1, 1, 0, 3, OPI),  32'd0,        32'd0,     32'hFFFF_FFFF};
      vecs[12] = '{"sltiu", enc_i(-1, 1, 3, 3, OPI),  32'd5,        32'd0,     32'd1};
      vecs[13] = '{"xori",  enc_i(-1, 1, 4, 3, OPI),  32'h0000_FFFF, 32'd0,    32'hFFFF_0000};
      vecs[14] = '{"srai",  enc_i(32'h41F, 1, 5, 3, OPI), 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
      vecs[15] = '{"andi",  enc_i(32'h0F0, 1, 7, 3, OPI), 32'h1234_5678, 32'd0, 32'h0000_0070};
      vecs[16] = '{"slti",  enc_i(-2, 1, 2, 3, OPI),  32'hFFFF_FFFF, 32'd0,    32'd0};
      vecs[17] = '{"srli",  enc_i(31, 1, 5, 3, OPI),  32'h8000_0000, 32'd0,    32'd1};

      // Table: x1=a, x2=b, op x3 at index 4
      for (int v = 0; v < 18; v++) begin
         prog.delete();
         li(1, vecs[v].a);
         li(2, vecs[v].b);
         prog.push_back(vecs[v].insn);
         prog.push_back(PARK);
         load_and_reset();
         step(4);
         check({vecs[v].name, ".rd_wdata"}, rvfi_rd_wdata, vecs[v].exp);
         step(1);
         check({vecs[v].name, ".x3"}, dut.regs[3], vecs[v].exp);
      end

      // ADDI chain and x0 write discard
      prog.delete();
      prog.push_back(enc_i(5, 0, 0, 1, OPI));
      prog.push_back(enc_i(-7, 1, 0, 2, OPI));
      prog.push_back(enc_i(1, 0, 0, 0, OPI));
      prog.push_back(PARK);
      load_and_reset();
      check("addi.valid", 32'(rvfi_valid), 32'h1);
      check("addi.pc0", rvfi_pc_rdata, 32'h0);
      step(1);
      check("addi.rd_addr", 32'(rvfi_rd_addr), 32'd2);
      check("addi.rd_wdata", rvfi_rd_wdata, 32'hFFFF_FFFE);
      step(1);
      check("x0.rd_addr", 32'(rvfi_rd_addr), 32'd0);
      check("x0.rd_wdata", rvfi_rd_wdata, 32'd0);
      step(1);
      check("addi.x1", dut.regs[1], 32'd5);
      check("addi.x2", dut.regs[2], 32'hFFFF_FFFE);

      // Loads/stores with byte enables and out-of-range dmem
      prog.delete();
      li(1, 32'h1234_5678);
      prog.push_back(enc_s(0, 1, 0, 2));
      prog.push_back(enc_s(1, 0, 0, 0));
      prog.push_back(enc_i(0, 0, 0, 3, OPL));
      prog.push_back(enc_i(0, 0, 5, 4, OPL));
      prog.push_back(enc_i(0, 0, 2, 5, OPL));
      prog.push_back(enc_i(800, 0, 0, 6, OPI));
      prog.push_back(enc_s(0, 1, 6, 2));
      prog.push_back(enc_i(0, 6, 2, 7, OPL));
      prog.push_back(enc_i(-128, 0, 0, 9, OPI));
      prog.push_back(enc_s(2, 9, 0, 0));
      prog.push_back(enc_i(2, 0, 0, 10, OPL));
      prog.push_back(enc_i(2, 0, 1, 11, OPL));
      prog.push_back(enc_s(6, 9, 0, 1));
      prog.push_back(PARK);
      load_and_reset();
      step(15);
      check("mem.x3_lb", dut.regs[3], 32'h0000_0078);
      check("mem.x4_lhu", dut.regs[4], 32'h0000_0078);
      check("mem.x5_lw", dut.regs[5], 32'h1234_0078);
      check("mem.x7_oob", dut.regs[7], 32'h0);
      check("mem.alias72", dut.dmem[72], 32'h0);
      check("mem.x10_lb_neg", dut.regs[10], 32'hFFFF_FF80);
      check("mem.x11_lh", dut.regs[11], 32'h0000_1280);
      check("mem.dmem0", dut.dmem[0], 32'h1280_0078);
      check("mem.dmem1_sh", dut.dmem[1], 32'hFF80_0000);

      // Countdown loop: 21 retirements before reaching PC 0xC
      prog.delete();
      prog.push_back(enc_i(10, 0, 0, 1, OPI));
      prog.push_back(enc_i(-1, 1, 0, 1, OPI));
      prog.push_back(enc_b(-4, 0, 1, 1));
      prog.push_back(PARK);
      load_and_reset();
      n = 0;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         if (rvfi_pc_rdata == 32'hC) done = 1;
         else begin
            if (rvfi_valid) n++;
            @(negedge clk);
         end
      end
      check("loop.done", 32'(done), 32'h1);
      check("loop.retired", 32'(n), 32'd21);
      check("loop.x1", dut.regs[1], 32'h0);

      // JAL / JALR with bit0 clearing
      prog.delete();
      for (int i = 0; i < 4; i++) prog.push_back(32'h0000_0013);
      prog.push_back(enc_j(8, 1));
      prog.push_back(enc_i(1, 0, 0, 5, OPI));
      prog.push_back(enc_i(5, 1, 0, 2, 7'h67));
      load_and_reset();
      step(4);
      check("jal.pc_wdata", rvfi_pc_wdata, 32'h18);
      check("jal.rd_wdata", rvfi_rd_wdata, 32'h14);
      step(1);
      check("jalr.pc_rdata", rvfi_pc_rdata, 32'h18);
      check("jalr.pc_wdata", rvfi_pc_wdata, 32'h18);
      check("jalr.rd_wdata", rvfi_rd_wdata, 32'h1C);
      step(1);
      check("jal.x2", dut.regs[2], 32'h1C);
      check("jal.skip_x5", dut.regs[5], 32'h0);

      // GPIO output, input, narrow-store rejection, AUIPC, unmapped read
      prog.delete();
      prog.push_back(enc_u(32'h80000, 1, 7'h37));
      prog.push_back(enc_i(-1, 0, 0, 2, OPI));
      prog.push_back(enc_s(4, 2, 1, 2));
      prog.push_back(enc_s(0, 2, 1, 2));
      prog.push_back(enc_s(4, 0, 1, 2));
      prog.push_back(enc_i(8, 1, 2, 3, OPL));
      prog.push_back(enc_s(0, 0, 1, 0));
      prog.push_back(enc_i(0, 1, 2, 4, OPL));
      prog.push_back(enc_u(1, 5, 7'h17));
      prog.push_back(enc_i(12, 1, 2, 6, OPL));
      prog.push_back(PARK);
      load_and_reset();
      step(4);
      check("gpio.out_pins", io_data, 32'hFFFF_FFFF);
      step(1);
      ext_val = 32'hA5A5_A5A5;
      ext_en  = 1'b1;
      step(5);
      check("gpio.x3_pins", dut.regs[3], 32'hA5A5_A5A5);
      check("gpio.x4_sb_ignored", dut.regs[4], 32'hFFFF_FFFF);
      check("auipc.x5", dut.regs[5], 32'h0000_1020);
      check("gpio.x6_unmapped", dut.regs[6], 32'h0);
      ext_en = 1'b0;

      // Fetch beyond imem returns NOP
      prog.delete();
      prog.push_back(enc_u(32'h62, 1, 7'h37));
      prog.push_back(enc_i(0, 1, 0, 0, 7'h67));
      load_and_reset();
      step(2);
      check("imem_oob.pc", rvfi_pc_rdata, 32'h0006_2000);
      check("imem_oob.insn", rvfi_insn, 32'h0000_0013);
      check("imem_oob.next", rvfi_pc_wdata, 32'h0006_2004);

      // Reset asserted mid-loop
      prog.delete();
      prog.push_back(enc_i(10, 0, 0, 1, OPI));
      prog.push_back(enc_i(-1, 1, 0, 1, OPI));
      prog.push_back(enc_b(-4, 0, 1, 1));
      prog.push_back(PARK);
      load_and_reset();
      dut.dmem[5] = 32'hDEAD_BEEF;
      step(7);
      check("rst.x1_before", dut.regs[1], 32'd7);
      reset_n = 1'b0;
      #1;
      check("rst.valid_low", 32'(rvfi_valid), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("rst.pc", dut.pc, 32'h0);
      acc = 32'h0;
      for (int i = 0; i < 32; i++) acc |= dut.regs[i];
      check("rst.regs_or", acc, 32'h0);
      reset_n = 1'b1;
      #1;
      check("rst.valid_high", 32'(rvfi_valid), 32'h1);
      check("rst.pc_rdata", rvfi_pc_rdata, 32'h0);
      check("rst.dmem_kept", dut.dmem[5], 32'hDEAD_BEEF);
      step(21);
      check("rst.rerun_pc", rvfi_pc_rdata, 32'hC);
      check("rst.rerun_x1", dut.regs[1], 32'h0);

      check("pins.idle", 32'(pin_bad), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
